// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV64I pipeline (F/D/E/M/W).
//   Resolves load-use hazards and taken-branch redirects in the same cycle.
//   Freezes the whole pipeline while a multi-cycle data-memory access in M
//   is outstanding. A memory access that never completes within TIMEOUT
//   stalled cycles parks the pipeline in a sticky fault until reset.
//
// Parameters
//   CNT_W    width of the saturating stall-cycle counter
//   TIMEOUT  max consecutive memory-stall cycles before fault (>= 2)
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   rs1_D, rs2_D             source registers of the instruction in D
//   rs1_used_D, rs2_used_D   D instruction actually reads rs1 / rs2
//   rd_E, mem_read_E         destination / is-load of the instruction in E
//   branch_taken_E           E resolves a taken branch or jump
//   mem_en_M, dmem_ready     M holds a load/store; memory completes this cycle
//   stall_F..stall_M         hold PC, F/D, D/E, E/M registers
//   flush_D, flush_E         clear F/D, D/E registers to NOP
//   en_W                     load the M/W register (alu_out_W, ld_data_W)
//   mem_err                  sticky memory-timeout fault
//   stall_cnt                number of cycles with stall_F=1 (saturating)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rd_E,
    input  logic             mem_read_E,
    input  logic             branch_taken_E,
    input  logic             mem_en_M,
    input  logic             dmem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             en_W,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;

    logic mem_block;
    logic load_use;
    logic freeze;    // full pipeline hold, W not written
    logic resolve;   // apply normal branch / load-use / pass-through rules

    // Hazard terms. x0 is hardwired zero, so a load into it never hazards.
    assign mem_block = mem_en_M & ~dmem_ready;
    assign load_use  = mem_read_E & (rd_E != 5'd0) &
                       ((rs1_used_D & (rs1_D == rd_E)) |
                        (rs2_used_D & (rs2_D == rd_E)));

    // ------------------------------------------------------------------
    // State register and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and mode selection
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        freeze    = 1'b0;
        resolve   = 1'b0;

        case (state)
            RUN: begin
                if (mem_block) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end

            MEM_WAIT: begin
                // Upstream is frozen, so any branch / load-use seen now is
                // the one that was pending when the wait began; it takes
                // effect on the completing cycle.
                if (dmem_ready) begin
                    resolve   = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = FAULT;
                        wait_nxt  = '0;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end

            FAULT: begin
                freeze = 1'b1;
            end

            default: begin
                freeze    = 1'b1;
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage-register controls
    // ------------------------------------------------------------------
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        en_W    = 1'b0;

        if (!rst) begin
            if (freeze) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
            end else if (resolve) begin
                en_W = 1'b1;
                if (branch_taken_E) begin
                    // Redirect kills D and E, which also discards any
                    // load-use consumer, so no stall is needed.
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (load_use) begin
                    // Hold F/D, inject a bubble into E for one cycle.
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end
            end
        end
    end

    assign mem_err = (state == FAULT);

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_F && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
